gps_acq_scheduler: RTL and testbench

Sequences the C/A code generator and an external correlator through a serial GPS acquisition search. For each PRN enabled in a mask, the block:
- sweeps every code-phase bin;
- reloads and re-phases the code generator;
- triggers one correlator dwell and tracks the peak energy;
- emits one result per PRN over a valid/ready handshake.

It sits between the host/config register bank and the code-generator/correlator datapath.

---
 rtl/gps_pkg.sv | 21 ++
 rtl/acq_peak_track.sv | 33 +++
 rtl/gps_acq_scheduler.sv | 115 +++++++++++
 tb/tb_gps_acq_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gps_pkg.sv
// gps_pkg: shared constants, FSM states, result type and PRN-mask search helper
package gps_pkg;
  localparam int CA_CODE_LEN = 1023;
  localparam int PRN_W = 6;
  localparam int PRN_MAX = 32;
  typedef enum logic [2:0] {IDLE, SCAN, LOAD, SETTLE, DWELL, EVAL, REPORT, FINISH} acq_state_t;
  typedef struct packed {
    logic [PRN_W-1:0] prn;
    logic [9:0]       phase;
    logic [31:0]      energy;
    logic             detected;
  } acq_result_t;
  // {found, index} of the lowest set mask bit at or above from
  function automatic logic [PRN_W:0] next_prn(input logic [PRN_MAX-1:0] mask, input logic [PRN_W-1:0] from);
    logic [PRN_W:0] r;
    r = '0;
    for (int i = PRN_MAX - 1; i >= 0; i--)
      if (mask[i] && i >= int'(from)) r = {1'b1, PRN_W'(i)};
    return r;
  endfunction
endpackage

// File: rtl/acq_peak_track.sv
// acq_peak_track: running peak energy/phase over one PRN sweep plus threshold compares.
// GPS_ACQ_EARLY_EXIT_EN enables the early_hit flag for a dwell above threshold.
module acq_peak_track #(
  parameter int ENERGY_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                update,
  input  logic [ENERGY_W-1:0] energy,
  input  logic [ENERGY_W-1:0] threshold,
  input  logic [9:0]          phase,
  output logic [ENERGY_W-1:0] peak_energy,
  output logic [9:0]          peak_phase,
  output logic                early_hit,
  output logic                detected
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      peak_energy <= '0;
      peak_phase  <= '0;
    end else if (update && energy > peak_energy) begin
      peak_energy <= energy;
      peak_phase  <= phase;
    end
  end
  assign detected = peak_energy > threshold;
`ifdef GPS_ACQ_EARLY_EXIT_EN
  assign early_hit = energy > threshold;
`else
  assign early_hit = 1'b0;
`endif
endmodule

// File: rtl/gps_acq_scheduler.sv
// gps_acq_scheduler: serial PRN x code-phase acquisition sequencer for code generator and correlator.
// GPS_ACQ_EARLY_EXIT_EN ends a PRN sweep at the first dwell above threshold.
module gps_acq_scheduler
  import gps_pkg::*;
#(
  parameter int NUM_PHASES = CA_CODE_LEN,
  parameter int ENERGY_W   = 32,
  parameter int SETTLE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [31:0]         prn_mask,
  input  logic [ENERGY_W-1:0] threshold,
  output logic                busy,
  output logic                gen_rst,
  output logic [PRN_W-1:0]    gen_prn,
  output logic [31:0]         gen_correction,
  output logic                corr_start,
  input  logic                corr_done,
  input  logic [ENERGY_W-1:0] corr_energy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PRN_W-1:0]    res_prn,
  output logic [9:0]          res_phase,
  output logic [ENERGY_W-1:0] res_energy,
  output logic                res_detected,
  output logic                done
);
  localparam logic [9:0] LAST = 10'(NUM_PHASES - 1);
  acq_state_t state, nxt;
  logic [31:0] mask;
  logic [ENERGY_W-1:0] thr, energy_q, peak_energy;
  logic [PRN_W-1:0] idx, hit;
  logic [9:0] phase, peak_phase;
  logic [3:0] cnt;
  logic found, dwelling, early_hit, detected, exit_now;

  assign {found, hit} = next_prn(mask, idx);
  assign exit_now = phase == LAST || early_hit;

  always_comb begin
    nxt = state;
    if (abort && state != IDLE) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = start ? SCAN : IDLE;
        SCAN:    nxt = found ? LOAD : FINISH;
        LOAD:    nxt = SETTLE_CYC == 0 ? DWELL : SETTLE;
        SETTLE:  nxt = cnt == 4'(SETTLE_CYC - 1) ? DWELL : SETTLE;
        DWELL:   nxt = corr_done ? EVAL : DWELL;
        EVAL:    nxt = exit_now ? REPORT : LOAD;
        REPORT:  nxt = res_ready ? SCAN : REPORT;
        default: nxt = IDLE;
      endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mask     <= '0;
      thr      <= '0;
      idx      <= '0;
      gen_prn  <= PRN_W'(1);
      phase    <= '0;
      cnt      <= '0;
      dwelling <= 1'b0;
      energy_q <= '0;
    end else begin
      state    <= nxt;
      cnt      <= state == SETTLE ? cnt + 4'd1 : 4'd0;
      dwelling <= state == DWELL;
      if (state == IDLE && start) begin
        mask <= prn_mask;
        thr  <= threshold;
        idx  <= '0;
      end
      if (state == SCAN && found) begin
        gen_prn <= hit + PRN_W'(1);
        idx     <= hit;
        phase   <= '0;
      end
      if (state == DWELL && corr_done) energy_q <= corr_energy;
      if (state == EVAL && !exit_now) phase <= phase + 10'd1;
      if (state == REPORT && res_ready) idx <= idx + PRN_W'(1);
    end
  end

  acq_peak_track #(.ENERGY_W(ENERGY_W)) u_peak (
    .clk(clk),
    .rst(rst),
    .clear(state == SCAN && found),
    .update(state == EVAL),
    .energy(energy_q),
    .threshold(thr),
    .phase(phase),
    .peak_energy(peak_energy),
    .peak_phase(peak_phase),
    .early_hit(early_hit),
    .detected(detected)
  );

  // corr_start fires only on the cycle DWELL is entered
  assign busy           = state != IDLE;
  assign gen_rst        = state == LOAD;
  assign gen_correction = 32'(phase);
  assign corr_start     = state == DWELL && !dwelling;
  assign res_valid      = state == REPORT;
  assign res_prn        = res_valid ? gen_prn : '0;
  assign res_phase      = res_valid ? peak_phase : '0;
  assign res_energy     = res_valid ? peak_energy : '0;
  assign res_detected   = res_valid && detected;
  assign done           = state == FINISH;
endmodule

// File: tb/tb_gps_acq_scheduler.sv
// tb_gps_acq_scheduler: randomized bench with a sweep-level reference model of the acquisition search
module tb_gps_acq_scheduler;
  localparam int NP = 4, ST = 2, EW = 32;
`ifdef GPS_ACQ_EARLY_EXIT_EN
  localparam int T2_LOADS = 2, T6_LOADS = 3;
`else
  localparam int T2_LOADS = 4, T6_LOADS = 4;
`endif
  logic clk = 0, rst = 1, start = 0, abort, corr_done, res_ready;
  logic [31:0] prn_mask = 0;
  logic [EW-1:0] threshold = 0, corr_energy;
  logic busy, gen_rst, corr_start, res_valid, res_detected, done;
  logic [5:0] gen_prn, res_prn;
  logic [31:0] gen_correction;
  logic [9:0] res_phase;
  logic [EW-1:0] res_energy;

  gps_acq_scheduler #(.NUM_PHASES(NP), .ENERGY_W(EW), .SETTLE_CYC(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prn_mask(prn_mask), .threshold(threshold),
    .busy(busy), .gen_rst(gen_rst), .gen_prn(gen_prn), .gen_correction(gen_correction),
    .corr_start(corr_start), .corr_done(corr_done), .corr_energy(corr_energy),
    .res_valid(res_valid), .res_ready(res_ready), .res_prn(res_prn), .res_phase(res_phase),
    .res_energy(res_energy), .res_detected(res_detected), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int prn; int phase; int energy; bit det; } res_t;
  int etab [1:32][0:NP-1];
  res_t exp_res[$];
  int exp_load[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, rst_cyc = 0, n_rst = 0, n_cs = 0, n_done = 0, n_res = 0;
  int last_prn = 0, last_phase = 0, last_energy = 0, ready_mode = 0;
  bit last_det = 0, spur = 0, abort_next = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Expected reloads and results for one search, straight from the sweep rules
  task automatic build_model(input logic [31:0] m, input int thr);
    for (int p = 1; p <= 32; p++)
      if (m[p-1]) begin
        automatic int pk = 0, ph = 0;
        for (int f = 0; f < NP; f++) begin
          exp_load.push_back(p * 1024 + f);
          if (etab[p][f] > pk) begin pk = etab[p][f]; ph = f; end
`ifdef GPS_ACQ_EARLY_EXIT_EN
          if (etab[p][f] > thr) break;
`endif
        end
        exp_res.push_back('{p, ph, pk, pk > thr});
      end
  endtask

  task automatic fill(input int maxe);
    for (int p = 1; p <= 32; p++)
      for (int f = 0; f < NP; f++) etab[p][f] = $urandom_range(0, maxe);
  endtask

  task automatic set1(input int a, input int b, input int c, input int d);
    etab[1][0] = a; etab[1][1] = b; etab[1][2] = c; etab[1][3] = d;
  endtask

  task automatic wait_done(input int d0);
    automatic int n = 0;
    while (n_done == d0 && n < 20000) begin @(negedge clk); n++; end
    if (n_done == d0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done after %0d cycles, required a done pulse", n);
      summary();
    end
  endtask

  task automatic run(input logic [31:0] m, input int thr, input bit poke);
    automatic int d0 = n_done;
    build_model(m, thr);
    @(posedge clk); #1 prn_mask = m; threshold = EW'(thr); start = 1;
    @(posedge clk); #1 start = 0;
    if (poke) begin
      repeat (4) @(posedge clk);
      #1 start = 1; prn_mask = ~m; threshold = ~threshold;
      @(posedge clk); #1 start = 0;
    end
    wait_done(d0);
  endtask

  // Compare process: checks every reload, dwell start, result cycle and done against the model
  initial begin
    int e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (gen_rst) begin
          n_rst++; rst_cyc = cyc;
          if (exp_load.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_gen_rst: prn %0d corr %0d, required no reload", gen_prn, gen_correction);
          end else begin
            e = exp_load.pop_front();
            chk("gen_prn", 64'(gen_prn), 64'(e / 1024));
            chk("gen_correction", 64'(gen_correction), 64'(e % 1024));
          end
        end
        if (corr_start) begin
          n_cs++;
          chk("settle_gap", 64'(cyc - rst_cyc), 64'(ST + 1));
        end
        if (res_valid) begin
          if (exp_res.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_result: prn %0d phase %0d, required no result", res_prn, res_phase);
          end else begin
            chk("res_prn", 64'(res_prn), 64'(exp_res[0].prn));
            chk("res_phase", 64'(res_phase), 64'(exp_res[0].phase));
            chk("res_energy", 64'(res_energy), 64'(exp_res[0].energy));
            chk("res_detected", 64'(res_detected), 64'(exp_res[0].det));
            if (res_ready) begin
              n_res++;
              last_prn = int'(res_prn); last_phase = int'(res_phase);
              last_energy = int'(res_energy); last_det = res_detected;
              void'(exp_res.pop_front());
            end
          end
        end
        if (done) begin
          n_done++;
          chk("done_loads_left", 64'(exp_load.size()), 64'(0));
          chk("done_results_left", 64'(exp_res.size()), 64'(0));
        end
        if (abort && busy) begin exp_load.delete(); exp_res.delete(); end
      end
    end
  end

  // Correlator responder: spurious done during SETTLE, real done 1..4 cycles after corr_start
  initial begin
    corr_done = 0; corr_energy = 0; abort = 0;
    forever begin
      @(negedge clk);
      if (gen_rst && spur) begin
        @(posedge clk); #1 corr_done = 1; corr_energy = '1;
        @(posedge clk); #1 corr_done = 0; corr_energy = 0;
      end else if (corr_start) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 corr_done = 1; corr_energy = EW'(etab[gen_prn][int'(gen_correction)]); abort = abort_next;
        @(posedge clk); #1 corr_done = 0; abort = 0; abort_next = 0;
      end
    end
  end

  // Result consumer: random ready, or hold ready low for 10 valid cycles
  initial begin
    int run_len;
    run_len = 0; res_ready = 0;
    forever begin
      @(posedge clk); #1;
      run_len = res_valid ? run_len + 1 : 0;
      res_ready = ready_mode == 0 ? 1'($urandom_range(0, 1)) : run_len > 10;
    end
  end

  initial begin
    int r0, c0, d0, q0, n;
    logic [31:0] m;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_gen_rst", 64'(gen_rst), 0);
    chk("rst_gen_prn", 64'(gen_prn), 1);
    chk("rst_gen_correction", 64'(gen_correction), 0);
    chk("rst_corr_start", 64'(corr_start), 0);
    chk("rst_res_valid", 64'(res_valid), 0);
    chk("rst_res_prn", 64'(res_prn), 0);
    chk("rst_res_energy", 64'(res_energy), 0);
    chk("rst_done", 64'(done), 0);
    @(posedge clk); #1 rst = 0;

    r0 = n_rst; c0 = n_cs; d0 = n_done;
    @(posedge clk); #1 prn_mask = 0; start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk); chk("empty_busy1", 64'(busy), 1); chk("empty_done1", 64'(done), 0);
    @(negedge clk); chk("empty_busy2", 64'(busy), 1); chk("empty_done2", 64'(done), 1);
    @(negedge clk); chk("empty_busy3", 64'(busy), 0); chk("empty_done3", 64'(done), 0);
    chk("empty_gen_rst", 64'(n_rst - r0), 0);
    chk("empty_corr_start", 64'(n_cs - c0), 0);
    chk("empty_done_count", 64'(n_done - d0), 1);

    set1(5, 9, 9, 3); ready_mode = 0; r0 = n_rst;
    run(32'h1, 8, 0);
    chk("tie_loads", 64'(n_rst - r0), 64'(T2_LOADS));
    chk("tie_prn", 64'(last_prn), 1);
    chk("tie_phase", 64'(last_phase), 1);
    chk("tie_energy", 64'(last_energy), 9);
    chk("tie_detected", 64'(last_det), 1);

    for (int p = 1; p <= 32; p++) for (int f = 0; f < NP; f++) etab[p][f] = 1;
    ready_mode = 1; q0 = n_res;
    run(32'h8000_0003, 1, 0);
    chk("multi_count", 64'(n_res - q0), 3);
    chk("multi_last_prn", 64'(last_prn), 32);
    chk("multi_last_det", 64'(last_det), 0);
    ready_mode = 0;

    fill(15); spur = 1;
    run(32'h0000_0104, 7, 0);
    spur = 0;

    fill(15); abort_next = 1; d0 = n_done; q0 = n_res;
    build_model(32'h1, 3);
    @(posedge clk); #1 prn_mask = 32'h1; threshold = 3; start = 1;
    @(posedge clk); #1 start = 0;
    n = 0;
    while (!(abort && busy) && n < 200) begin @(negedge clk); n++; end
    if (!(abort && busy)) begin
      n_cmp++; n_bad++;
      $display("FAIL abort_timeout: no abort after %0d cycles, required abort in DWELL", n);
      summary();
    end
    chk("abort_with_done", 64'(corr_done), 1);
    @(negedge clk);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_res_valid", 64'(res_valid), 0);
    chk("abort_corr_start", 64'(corr_start), 0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", 64'(n_done - d0), 0);
    chk("abort_no_result", 64'(n_res - q0), 0);
    fill(15);
    run(32'h0000_0011, 6, 1);

    set1(0, 0, 100, 0); r0 = n_rst;
    run(32'h1, 50, 0);
    chk("early_loads", 64'(n_rst - r0), 64'(T6_LOADS));
    chk("early_phase", 64'(last_phase), 2);
    chk("early_energy", 64'(last_energy), 100);
    chk("early_detected", 64'(last_det), 1);

    for (int k = 0; k < 12; k++) begin
      fill(15);
      m = k == 0 ? 32'hFFFF_FFFF : $urandom & $urandom & $urandom;
      spur = 1'($urandom_range(0, 1));
      run(m, $urandom_range(0, 15), m != 0);
    end
    spur = 0;
    repeat (3) @(negedge clk);
    summary();
  end
endmodule
